writeback_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback logic; consumes the memory stage outputs.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/load_extend_unit.sv | 22 ++
 rtl/writeback_stage.sv | 57 +++++
 tb/tb_writeback_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared writeback constants and the MEM/WB register layout
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus_4;
    } mwb_t;
endpackage

// File: rtl/load_extend_unit.sv
// load_extend_unit: picks the byte/halfword lane of a loaded word and extends it
// Ports: funct3 (load type), addr (byte offset), word (aligned memory word), data (extended result)
module load_extend_unit
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = 8'(word >> {addr, 3'b000});
        // addr[0] is ignored for halfwords: misaligned halfwords read the enclosing lane
        h = addr[1] ? word[31:16] : word[15:0];
        data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
               funct3 == F3_LBU ? {24'b0, b} :
               funct3 == F3_LH  ? {{16{h[15]}}, h} :
               funct3 == F3_LHU ? {16'b0, h} : word;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extension and register-file write result mux
// Ports: clk, rst_n (async active-low), stall_w/flush_w (hold/bubble), *_m memory stage inputs,
//        valid_w, reg_write_w, rd_w, result_w (write port and forwarding), instret_w (retire count)
// Optional: RETIRE_COUNT_EN adds the retired-instruction counter; otherwise instret_w is 0
module writeback_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic             reg_write_m,
    input  logic [1:0]       result_src_m,
    input  logic [2:0]       funct3_m,
    input  logic [4:0]       rd_m,
    input  logic [XLEN-1:0]  alu_result_m,
    input  logic [XLEN-1:0]  read_data_m,
    input  logic [XLEN-1:0]  pc_plus_4_m,
    output logic             valid_w,
    output logic             reg_write_w,
    output logic [4:0]       rd_w,
    output logic [XLEN-1:0]  result_w,
    output logic [CNT_W-1:0] instret_w
);
    import riscv_pkg::*;
    mwb_t q;
    logic [XLEN-1:0] load_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (flush_w) q <= '0;
        else if (!stall_w) q <= '{valid_m, reg_write_m & valid_m & (rd_m != 5'd0), rd_m, result_src_m,
                                  funct3_m, alu_result_m, read_data_m, pc_plus_4_m};
    end
    load_extend_unit u_lext (
        .funct3(q.funct3),
        .addr  (q.alu_result[1:0]),
        .word  (q.read_data),
        .data  (load_data)
    );
    assign valid_w     = q.valid;
    assign reg_write_w = q.reg_write;
    assign rd_w        = q.rd;
    assign result_w    = q.result_src == RESULT_SRC_LOAD ? load_data :
                         q.result_src == RESULT_SRC_PC4  ? q.pc_plus_4 : q.alu_result;
`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (valid_m && !stall_w && !flush_w) cnt <= cnt + 1'b1;
    end
    assign instret_w = cnt;
`else
    assign instret_w = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for writeback_stage
module tb_writeback_stage;
    logic        clk = 0, rst_n = 0, stall_w = 0, flush_w = 0, valid_m = 0, reg_write_m = 0;
    logic [1:0]  result_src_m = 0;
    logic [2:0]  funct3_m = 0;
    logic [4:0]  rd_m = 0;
    logic [31:0] alu_result_m = 0, read_data_m = 0, pc_plus_4_m = 0;
    logic        valid_w, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [63:0] instret_w;
    typedef struct packed {logic v; logic rw; logic [4:0] rd; logic [31:0] res;} exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;
    logic [63:0] cnt_exp = 0;
    localparam logic [31:0] W = 32'h80FF7F01;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
        .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .instret_w(instret_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t x);
        chk({tag, ".valid"}, 64'(valid_w), 64'(x.v));
        chk({tag, ".reg_write"}, 64'(reg_write_w), 64'(x.rw));
        chk({tag, ".rd"}, 64'(rd_w), 64'(x.rd));
        chk({tag, ".result"}, 64'(result_w), 64'(x.res));
`ifdef RETIRE_COUNT_EN
        chk({tag, ".instret"}, instret_w, cnt_exp);
`else
        chk({tag, ".instret"}, instret_w, 64'd0);
`endif
    endtask

    task automatic step(input string tag, input logic st, fl, v, rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu, rdata, pc4,
                        input logic ev, erw, input logic [4:0] erd, input logic [31:0] eres);
        @(negedge clk);
        stall_w = st; flush_w = fl; valid_m = v; reg_write_m = rw; result_src_m = src;
        funct3_m = f3; rd_m = rd; alu_result_m = alu; read_data_m = rdata; pc_plus_4_m = pc4;
        sb.push_back('{ev, erw, erd, eres});
        if (v && !st && !fl) cnt_exp++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(tag, e);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 0;
        cnt_exp = 0;
        #1 chk_all(tag, '0);
        @(negedge clk);
        rst_n = 1; stall_w = 0; flush_w = 0;
    endtask

    initial begin
        #1 chk_all("reset0", '0);
        @(negedge clk) rst_n = 1;
        step("lb3",  0, 0, 1, 1, 2'b01, 3'b000, 5'd5, 32'h1003, W, 0, 1, 1, 5'd5, 32'hFFFFFF80);
        step("lbu3", 0, 0, 1, 1, 2'b01, 3'b100, 5'd6, 32'h1003, W, 0, 1, 1, 5'd6, 32'h00000080);
        step("lb1",  0, 0, 1, 1, 2'b01, 3'b000, 5'd7, 32'h1001, W, 0, 1, 1, 5'd7, 32'h0000007F);
        step("lh2",  0, 0, 1, 1, 2'b01, 3'b001, 5'd8, 32'h1002, W, 0, 1, 1, 5'd8, 32'hFFFF80FF);
        step("lhu0", 0, 0, 1, 1, 2'b01, 3'b101, 5'd9, 32'h1000, W, 0, 1, 1, 5'd9, 32'h00007F01);
        step("lh1",  0, 0, 1, 1, 2'b01, 3'b001, 5'd10, 32'h1001, W, 0, 1, 1, 5'd10, 32'h00007F01);
        step("lw",   0, 0, 1, 1, 2'b01, 3'b010, 5'd11, 32'h1003, W, 0, 1, 1, 5'd11, W);
        step("f3_7", 0, 0, 1, 1, 2'b01, 3'b111, 5'd12, 32'h1001, W, 0, 1, 1, 5'd12, W);
        step("pc4",  0, 0, 1, 1, 2'b10, 3'b010, 5'd13, 32'h77, W, 32'h104, 1, 1, 5'd13, 32'h104);
        step("src3", 0, 0, 1, 1, 2'b11, 3'b010, 5'd14, 32'h55, W, 32'h104, 1, 1, 5'd14, 32'h55);
        step("rd0",  0, 0, 1, 1, 2'b00, 3'b010, 5'd0, 32'h11, W, 0, 1, 0, 5'd0, 32'h11);
        step("inv",  0, 0, 0, 1, 2'b00, 3'b010, 5'd7, 32'h22, W, 0, 0, 0, 5'd7, 32'h22);
        step("cap",  0, 0, 1, 1, 2'b00, 3'b010, 5'd9, 32'hAA, W, 0, 1, 1, 5'd9, 32'hAA);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 1, 1, 2'b00, 3'b010, 5'd3, 32'hBB, W, 0, 1, 1, 5'd9, 32'hAA);
        step("post", 0, 0, 1, 1, 2'b00, 3'b010, 5'd3, 32'hBB, W, 0, 1, 1, 5'd3, 32'hBB);
        step("flst", 1, 1, 1, 1, 2'b01, 3'b000, 5'd4, 32'hCC, W, 0, 0, 0, 5'd0, 32'h0);
        step("cap2", 0, 0, 1, 1, 2'b10, 3'b010, 5'd4, 32'hCC, W, 32'h200, 1, 1, 5'd4, 32'h200);
        stall_w = 1;
        async_reset("rst_stall");
        step("c1", 0, 0, 1, 1, 2'b00, 3'b010, 5'd1, 32'h1, W, 0, 1, 1, 5'd1, 32'h1);
        step("c2", 0, 0, 1, 1, 2'b00, 3'b010, 5'd2, 32'h2, W, 0, 1, 1, 5'd2, 32'h2);
        for (int i = 0; i < 3; i++)
            step("c_st", 1, 0, 1, 1, 2'b00, 3'b010, 5'd3, 32'h3, W, 0, 1, 1, 5'd2, 32'h2);
        step("c3", 0, 0, 1, 1, 2'b00, 3'b010, 5'd3, 32'h3, W, 0, 1, 1, 5'd3, 32'h3);
        step("c4", 0, 0, 1, 1, 2'b00, 3'b010, 5'd4, 32'h4, W, 0, 1, 1, 5'd4, 32'h4);
        step("c5", 0, 0, 1, 1, 2'b00, 3'b010, 5'd5, 32'h5, W, 0, 1, 1, 5'd5, 32'h5);
`ifdef RETIRE_COUNT_EN
        chk("instret5", instret_w, 64'd5);
`endif
        flush_w = 1;
        async_reset("rst_flush");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
